// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front end.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } btn_state_t;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous pin, synchronous active-low reset.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_engine.sv
// Debounced push-button engine: level, press/release/long-press pulses.
// Define BTN_AUTOREPEAT_EN to repeat press every REPEAT_CNT cycles after a long press.
module button_engine
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 250000,
    parameter int LONG_CNT     = 50000000,
    parameter int REPEAT_CNT   = 12500000,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse,   // "release" is a reserved word
    output logic long_press
);

    localparam int DW = cnt_width(DEBOUNCE_CNT);
    localparam int HW = cnt_width((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT);
    localparam logic [DW-1:0] DLOAD = DW'(DEBOUNCE_CNT - 1);
    localparam logic [HW-1:0] HMAX  = HW'(LONG_CNT);
    localparam logic [HW-1:0] HLONG = HW'(LONG_CNT - 1);

    logic            s2;
    btn_state_t      state, state_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic            hold_inc, accept_press, accept_release, long_fire, rep_fire;
    logic            level_nxt, press_nxt, release_nxt, long_nxt;

    btn_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn ^ ACTIVE_LOW),
        .q     (s2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RELEASED;
            dcnt          <= '0;
            hold          <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            dcnt          <= dcnt_nxt;
            hold          <= hold_nxt;
            level         <= level_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
        end
    end

    // hold_inc marks every cycle the button is considered held and stays held.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        hold_inc  = 1'b0;
        case (state)
            RELEASED: begin
                if (s2) begin
                    state_nxt = PRESS_PEND;
                    dcnt_nxt  = DLOAD;
                end
            end
            PRESS_PEND: begin
                if (!s2)              state_nxt = RELEASED;
                else if (dcnt == '0)  state_nxt = PRESSED;
                else                  dcnt_nxt  = dcnt - DW'(1);
            end
            PRESSED: begin
                hold_inc = 1'b1;
                if (!s2) begin
                    state_nxt = RELEASE_PEND;
                    dcnt_nxt  = DLOAD;
                end
            end
            RELEASE_PEND: begin
                if (s2) begin
                    state_nxt = PRESSED;
                    hold_inc  = 1'b1;
                end else if (dcnt == '0) begin
                    state_nxt = RELEASED;
                end else begin
                    dcnt_nxt = dcnt - DW'(1);
                    hold_inc = 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

    assign accept_press   = (state == PRESS_PEND) && s2 && (dcnt == '0);
    assign accept_release = (state == RELEASE_PEND) && !s2 && (dcnt == '0);
    assign long_fire      = hold_inc && (hold == HLONG);

    always_comb begin
        hold_nxt = hold;
        if (accept_press)                    hold_nxt = '0;
        else if (hold_inc && (hold != HMAX)) hold_nxt = hold + HW'(1);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HW-1:0] RLOAD = HW'(REPEAT_CNT - 1);

    logic          armed;
    logic [HW-1:0] rcnt;

    assign rep_fire = armed && hold_inc && (rcnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b0;
            rcnt  <= '0;
        end else if (accept_press || accept_release) begin
            armed <= 1'b0;
        end else if (long_fire) begin
            armed <= 1'b1;
            rcnt  <= RLOAD;
        end else if (armed && hold_inc) begin
            rcnt  <= (rcnt == '0) ? RLOAD : rcnt - HW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        level_nxt   = level;
        press_nxt   = accept_press | rep_fire;
        release_nxt = accept_release;
        long_nxt    = long_fire;
        if (accept_press)        level_nxt = 1'b1;
        else if (accept_release) level_nxt = 1'b0;
    end

endmodule

// File: tb/tb_button_engine.sv
// Self-checking bench for button_engine: directed scenarios plus random bouncing input,
// compared against a run-length reference model; a second instance runs ACTIVE_LOW=1.
module tb_button_engine;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic btn_n;
    logic level, press, rel, long_press;
    logic level_a, press_a, rel_a, long_a;

    assign btn_n = ~btn;

    button_engine #(.DEBOUNCE_CNT(D), .LONG_CNT(L), .REPEAT_CNT(R), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .level(level), .press(press),
        .release_pulse(rel), .long_press(long_press)
    );

    button_engine #(.DEBOUNCE_CNT(D), .LONG_CNT(L), .REPEAT_CNT(R), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .btn(btn_n), .level(level_a), .press(press_a),
        .release_pulse(rel_a), .long_press(long_a)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc, mism, first_cyc;
    int n_press, n_rel, n_long;
    int first_press, first_press_a, first_rel, first_long;
    logic [3:0] first_obs, first_obs_a, first_exp;

    // Reference model: level flips once the synchronised input has disagreed with it
    // for D+1 consecutive cycles; hold time is counted in cycles since the press pulse.
    bit m_s1, m_s2, m_level, m_press, m_rel, m_long;
    int run, hold;
`ifdef BTN_AUTOREPEAT_EN
    int rep;
`endif

    task automatic model_edge();
        bit seen;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0;
            m_press = 0; m_rel = 0; m_long = 0;
            run = 0; hold = 0;
`ifdef BTN_AUTOREPEAT_EN
            rep = 0;
`endif
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = btn;
            m_press = 0; m_rel = 0; m_long = 0;
            run = (seen != m_level) ? run + 1 : 0;
            if (run == D + 1) begin
                run = 0;
                if (!m_level) begin
                    m_level = 1; m_press = 1; hold = 0;
                end else begin
                    m_level = 0; m_rel = 1;
                end
            end else if (m_level) begin
                if (hold < L) begin
                    hold++;
                    if (hold == L) begin
                        m_long = 1;
`ifdef BTN_AUTOREPEAT_EN
                        rep = 0;
`endif
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                else begin
                    rep++;
                    if (rep == R) begin
                        m_press = 1;
                        rep = 0;
                    end
                end
`endif
            end
        end
    endtask

    task automatic clear_stats();
        cyc = -1; mism = 0; first_cyc = -1;
        n_press = 0; n_rel = 0; n_long = 0;
        first_press = -1; first_press_a = -1; first_rel = -1; first_long = -1;
    endtask

    // One clock: drive btn, advance the model, sample both instances at the falling edge.
    task automatic step(input bit b);
        logic [3:0] obs, obs_a, exp_v;
        btn = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        obs   = {level, press, rel, long_press};
        obs_a = {level_a, press_a, rel_a, long_a};
        exp_v = {m_level, m_press, m_rel, m_long};
        if (obs !== exp_v || obs_a !== exp_v) begin
            if (mism == 0) begin
                first_obs = obs; first_obs_a = obs_a; first_exp = exp_v; first_cyc = cyc;
            end
            mism++;
        end
        if (press === 1'b1) begin
            n_press++;
            if (first_press < 0) first_press = cyc;
        end
        if (press_a === 1'b1 && first_press_a < 0) first_press_a = cyc;
        if (rel === 1'b1) begin
            n_rel++;
            if (first_rel < 0) first_rel = cyc;
        end
        if (long_press === 1'b1) begin
            n_long++;
            if (first_long < 0) first_long = cyc;
        end
    endtask

    task automatic test_reset();
        clear_stats();
        rst_n = 1'b0;
        step(1); step(1); step(0);
        checks++;
        if ({level, press, rel, long_press, level_a, press_a, rel_a, long_a} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b/%b%b%b%b want=0000/0000", level, press, rel,
                     long_press, level_a, press_a, rel_a, long_a);
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL reset_trace cyc=%0d got=%b al=%b want=%b", first_cyc, first_obs, first_obs_a, first_exp);
        end
        rst_n = 1'b1;
        repeat (4) step(0);
    endtask

    task automatic test_clean_press();
        clear_stats();
        repeat (12) step(1);
        checks++;
        if (first_press !== 6) begin
            failures++;
            $display("FAIL clean_press_latency got=%0d want=6", first_press);
        end
        checks++;
        if (n_press !== 1 || level !== 1'b1) begin
            failures++;
            $display("FAIL clean_press_count got=%0d level=%b want=1 level=1", n_press, level);
        end
        repeat (12) step(0);
        checks++;
        if (n_rel !== 1 || level !== 1'b0) begin
            failures++;
            $display("FAIL clean_release got=%0d level=%b want=1 level=0", n_rel, level);
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL clean_trace cyc=%0d got=%b al=%b want=%b", first_cyc, first_obs, first_obs_a, first_exp);
        end
    endtask

    task automatic test_glitch();
        clear_stats();
        repeat (3) step(1);
        repeat (10) step(0);
        checks++;
        if (n_press !== 0 || n_rel !== 0 || level !== 1'b0) begin
            failures++;
            $display("FAIL glitch_quiet got press=%0d rel=%0d level=%b want 0 0 0", n_press, n_rel, level);
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL glitch_trace cyc=%0d got=%b al=%b want=%b", first_cyc, first_obs, first_obs_a, first_exp);
        end
    endtask

    task automatic test_bouncy_release();
        repeat (10) step(1);
        clear_stats();
        for (int i = 0; i < 6; i++) step((i % 2) != 0);
        repeat (12) step(0);
        checks++;
        if (n_rel !== 1 || n_press !== 0) begin
            failures++;
            $display("FAIL bouncy_counts got rel=%0d press=%0d want rel=1 press=0", n_rel, n_press);
        end
        checks++;
        if (first_rel !== 12) begin
            failures++;
            $display("FAIL bouncy_release_time got=%0d want=12", first_rel);
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL bouncy_trace cyc=%0d got=%b al=%b want=%b", first_cyc, first_obs, first_obs_a, first_exp);
        end
    endtask

    task automatic test_long_hold();
        int want_press;
`ifdef BTN_AUTOREPEAT_EN
        want_press = 4;
`else
        want_press = 1;
`endif
        clear_stats();
        repeat (40) step(1);
        repeat (12) step(0);
        checks++;
        if (n_long !== 1 || (first_long - first_press) !== L) begin
            failures++;
            $display("FAIL long_press got n=%0d delay=%0d want n=1 delay=%0d", n_long, first_long - first_press, L);
        end
        checks++;
        if (n_press !== want_press) begin
            failures++;
            $display("FAIL long_press_count got=%0d want=%0d", n_press, want_press);
        end
        checks++;
        if (n_rel !== 1) begin
            failures++;
            $display("FAIL long_release got=%0d want=1", n_rel);
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL long_trace cyc=%0d got=%b al=%b want=%b", first_cyc, first_obs, first_obs_a, first_exp);
        end
    endtask

    task automatic test_reset_mid_press();
        clear_stats();
        repeat (10) step(1);
        rst_n = 1'b0;
        step(1); step(1);
        checks++;
        if ({level, press, rel, long_press, level_a, press_a, rel_a, long_a} !== 8'h00) begin
            failures++;
            $display("FAIL midreset_outputs got=%b%b%b%b/%b%b%b%b want=0000/0000", level, press, rel,
                     long_press, level_a, press_a, rel_a, long_a);
        end
        rst_n = 1'b1;
        cyc = -1; first_press = -1; n_press = 0;
        repeat (12) step(1);
        checks++;
        if (first_press !== 6 || n_press !== 1) begin
            failures++;
            $display("FAIL midreset_repress got at=%0d n=%0d want at=6 n=1", first_press, n_press);
        end
        checks++;
        if (n_rel !== 0) begin
            failures++;
            $display("FAIL midreset_no_release got=%0d want=0", n_rel);
        end
        repeat (12) step(0);
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL midreset_trace cyc=%0d got=%b al=%b want=%b", first_cyc, first_obs, first_obs_a, first_exp);
        end
    endtask

    task automatic test_active_low();
        clear_stats();
        repeat (10) step(1);
        checks++;
        if (first_press_a !== 6 || level_a !== 1'b1) begin
            failures++;
            $display("FAIL active_low_press got at=%0d level=%b want at=6 level=1", first_press_a, level_a);
        end
        repeat (12) step(0);
        checks++;
        if (level_a !== 1'b0 || mism !== 0) begin
            failures++;
            $display("FAIL active_low_trace level=%b cyc=%0d got=%b want=%b", level_a, first_cyc, first_obs_a, first_exp);
        end
    endtask

    task automatic test_random();
        bit val, b;
        int len;
        clear_stats();
        for (int seg = 0; seg < 50; seg++) begin
            val = bit'($urandom_range(1, 0));
            len = $urandom_range(30, 1);
            for (int i = 0; i < len; i++) begin
                b = ($urandom_range(7, 0) == 0) ? !val : val;
                rst_n = ($urandom_range(249, 0) != 0);
                step(b);
            end
        end
        rst_n = 1'b1;
        repeat (12) step(0);
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL random_trace cyc=%0d got=%b al=%b want=%b (mismatches=%0d)", first_cyc, first_obs,
                     first_obs_a, first_exp, mism);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bouncy_release();
        test_long_hold();
        test_reset_mid_press();
        test_active_low();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
